// File: rtl/td4_sequencer_if.sv
// Bundle between the TD4 sequencer and its datapath / program ROM / run controls.
interface td4_sequencer_if;
  logic       run;
  logic       step;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       alu_carry;
  logic [1:0] sel;
  logic [3:0] imm;
  logic       ld_a;
  logic       ld_b;
  logic       ld_out;
  logic [3:0] pc;
  logic       c_flag;
  logic       busy;
  logic       instr_done;

  modport master (
    input  run, step, rom_data, alu_carry,
    output rom_addr, sel, imm, ld_a, ld_b, ld_out, pc, c_flag, busy, instr_done
  );

  modport slave (
    output run, step, rom_data, alu_carry,
    input  rom_addr, sel, imm, ld_a, ld_b, ld_out, pc, c_flag, busy, instr_done
  );
endinterface

// File: rtl/td4_sequencer.sv
// TD4 fetch/decode/execute control: PC, instruction register, carry flag,
// adder source select and one-cycle load strobes.
//   state  | meaning
//   IDLE   | waiting for run or a step pulse
//   FETCH  | rom_addr=pc presented to the synchronous ROM
//   DECODE | ir captures rom_data
//   EXEC   | strobes, carry and PC update, one cycle
module td4_sequencer #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic           clk,
  input  logic           rst,
  td4_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FETCH  = 2'b01,
    DECODE = 2'b10,
    EXEC   = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       c_q, c_d;

  logic [1:0] sel_c;
  logic       ld_a_c, ld_b_c, ld_out_c;
  logic       jmp_c, jnc_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    c_d     = c_q;
    case (state_q)
      IDLE:   if (bus.run || bus.step) state_d = FETCH;
      FETCH:  state_d = DECODE;
      DECODE: begin
        ir_d    = bus.rom_data;
        state_d = EXEC;
      end
      EXEC: begin
        c_d = bus.alu_carry;
        // JNC tests the carry left by the previous instruction, not this one
        if (jmp_c || (jnc_c && !c_q)) pc_d = ir_q[3:0];
        else                          pc_d = pc_q + 4'd1;
        state_d = bus.run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_c    = 2'b00;
    ld_a_c   = 1'b0;
    ld_b_c   = 1'b0;
    ld_out_c = 1'b0;
    jmp_c    = 1'b0;
    jnc_c    = 1'b0;
    if (state_q == EXEC) begin
      case (ir_q[7:4])
        4'b0000: begin sel_c = 2'b00; ld_a_c   = 1'b1; end
        4'b0101: begin sel_c = 2'b01; ld_b_c   = 1'b1; end
        4'b0011: begin sel_c = 2'b11; ld_a_c   = 1'b1; end
        4'b0111: begin sel_c = 2'b11; ld_b_c   = 1'b1; end
        4'b0001: begin sel_c = 2'b01; ld_a_c   = 1'b1; end
        4'b0100: begin sel_c = 2'b00; ld_b_c   = 1'b1; end
        4'b0010: begin sel_c = 2'b10; ld_a_c   = 1'b1; end
        4'b0110: begin sel_c = 2'b10; ld_b_c   = 1'b1; end
        4'b1001: begin sel_c = 2'b01; ld_out_c = 1'b1; end
        4'b1011: begin sel_c = 2'b11; ld_out_c = 1'b1; end
        4'b1111: begin sel_c = 2'b11; jmp_c    = 1'b1; end
        4'b1110: begin sel_c = 2'b11; jnc_c    = 1'b1; end
        default: sel_c = 2'b00;
      endcase
    end
  end

  assign bus.rom_addr   = pc_q;
  assign bus.pc         = pc_q;
  assign bus.imm        = ir_q[3:0];
  assign bus.c_flag     = c_q;
  assign bus.sel        = sel_c;
  assign bus.ld_a       = ld_a_c;
  assign bus.ld_b       = ld_b_c;
  assign bus.ld_out     = ld_out_c;
  assign bus.busy       = (state_q != IDLE);
  assign bus.instr_done = (state_q == EXEC);

endmodule
